// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-way selector:
//   skid_state_t : skid-buffer occupancy encoding (EMPTY / ONE / TWO)
//   STATS_W      : width of the optional out-of-range beat counter
//   clog2        : ceiling log2, used to validate the select width
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  localparam int unsigned STATS_W = 16;

  // Smallest r such that 2**r >= n (0 for n <= 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_n_sel.sv
// Purely combinational N-way selector with range check.
// Ports:
//   sel    : select index
//   data   : flattened inputs, input k at [k*WIDTH +: WIDTH]
//   err_c  : 1 when sel >= NUM_IN
//   data_c : selected input, or DEFAULT_VAL when out of range
module mux_n_sel #(
  parameter int unsigned          WIDTH       = 32,
  parameter int unsigned          NUM_IN      = 3,
  parameter int unsigned          SEL_W       = 2,
  parameter logic [WIDTH-1:0]     DEFAULT_VAL = '0
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data,
  output logic                    err_c,
  output logic [WIDTH-1:0]        data_c
);

  // Compare against every legal index; no match leaves the default and error.
  always_comb begin
    data_c = DEFAULT_VAL;
    err_c  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        data_c = data[k*WIDTH +: WIDTH];
        err_c  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_reg.sv
// Registered N-way selector with valid/ready handshake and a 2-entry skid
// buffer so one beat per cycle is sustained under backpressure.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid / in_ready  : input handshake (in_ready is registered)
//   in_sel, in_data      : select and flattened data, sampled on input fire
//   out_valid / out_ready: output handshake
//   out_data, out_err    : selected value and out-of-range flag
// Optional (macro MUX_N_REG_STATS_EN):
//   stats_clr            : synchronous clear of err_count (beats increment)
//   err_count            : saturating count of out-of-range beats accepted
module mux_n_reg
  import mux_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      NUM_IN      = 3,
  parameter int unsigned      SEL_W       = 2,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err
`ifdef MUX_N_REG_STATS_EN
  ,
  input  logic                    stats_clr,
  output logic [STATS_W-1:0]      err_count
`endif
);

  // Reject configurations the select cannot address.
  if (SEL_W < clog2(NUM_IN)) begin : g_bad_sel_w
    $error("mux_n_reg: SEL_W too narrow for NUM_IN");
  end
  if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
    $error("mux_n_reg: NUM_IN must be in 2..16");
  end

  skid_state_t      state;
  logic [WIDTH-1:0] skid_data;
  logic             skid_err;
  logic [WIDTH-1:0] sel_data_c;
  logic             sel_err_c;
  logic             fire_in_c;
  logic             fire_out_c;

  assign fire_in_c  = in_valid & in_ready;
  assign fire_out_c = out_valid & out_ready;

  mux_n_sel #(
    .WIDTH       (WIDTH),
    .NUM_IN      (NUM_IN),
    .SEL_W       (SEL_W),
    .DEFAULT_VAL (DEFAULT_VAL)
  ) u_sel (
    .sel    (in_sel),
    .data   (in_data),
    .err_c  (sel_err_c),
    .data_c (sel_data_c)
  );

  // Skid-buffer FSM: main register drives out_*, skid holds the overflow beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (fire_in_c) begin
            out_data  <= sel_data_c;
            out_err   <= sel_err_c;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (fire_in_c && fire_out_c) begin
            out_data <= sel_data_c;
            out_err  <= sel_err_c;
          end else if (fire_in_c) begin
            skid_data <= sel_data_c;
            skid_err  <= sel_err_c;
            in_ready  <= 1'b0;
            state     <= TWO;
          end else if (fire_out_c) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (fire_out_c) begin
            out_data <= skid_data;
            out_err  <= skid_err;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= EMPTY;
        end
      endcase
    end
  end

`ifdef MUX_N_REG_STATS_EN
  // Saturating count of out-of-range beats; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (stats_clr) begin
      err_count <= '0;
    end else if (fire_in_c && sel_err_c && (err_count != '1)) begin
      err_count <= err_count + STATS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mux_n_reg.sv
module tb_mux_n_reg;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [SW-1:0]   in_sel;
  logic [N*W-1:0]  in_data;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            out_err;
`ifdef MUX_N_REG_STATS_EN
  logic            stats_clr;
  logic [15:0]     err_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit run_chk  = 1'b0;

  // Model: beats in flight, oldest first, as {err, data}.
  logic [W:0] q[$];
  int unsigned m_cnt;

  always #5 clk = ~clk;

  mux_n_reg #(
    .WIDTH       (W),
    .NUM_IN      (N),
    .SEL_W       (SW),
    .DEFAULT_VAL (32'h0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
`ifdef MUX_N_REG_STATS_EN
    ,
    .stats_clr (stats_clr),
    .err_count (err_count)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update: a 2-deep FIFO of selected beats, plus the saturating counter.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_cnt = 0;
    end else begin
      bit fin, fout;
      int s;
      logic [W:0] beat;
      fin  = in_valid && (q.size() < 2);
      fout = (q.size() > 0) && out_ready;
      s    = int'(in_sel);
      if (s < N) beat = {1'b0, in_data[s*W +: W]};
      else       beat = {1'b1, 32'h0};
`ifdef MUX_N_REG_STATS_EN
      if (stats_clr) m_cnt = 0;
      else if (fin && s >= N && m_cnt != 32'hFFFF) m_cnt = m_cnt + 1;
`endif
      if (fout) void'(q.pop_front());
      if (fin) q.push_back(beat);
    end
  end

  // Compare DUT against the model every cycle away from the clock edge.
  always @(negedge clk) begin
    if (run_chk && !reset) begin
      check("mdl_in_ready", 64'(in_ready), 64'(q.size() < 2));
      check("mdl_out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        check("mdl_out_data", 64'(out_data), 64'(q[0][W-1:0]));
        check("mdl_out_err", 64'(out_err), 64'(q[0][W]));
      end
`ifdef MUX_N_REG_STATS_EN
      check("mdl_err_count", 64'(err_count), 64'(m_cnt));
`endif
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef MUX_N_REG_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset   = 1'b0;
    run_chk = 1'b1;

    // Reset state
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_out_err", 64'(out_err), 64'h0);
`ifdef MUX_N_REG_STATS_EN
    check("rst_err_count", 64'(err_count), 64'h0);
`endif

    // Single beat, sel=1
    in_data   = {32'hC, 32'hB, 32'hA};
    in_sel    = 2'd1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("sel1_valid", 64'(out_valid), 64'h1);
    check("sel1_data", 64'(out_data), 64'hB);
    check("sel1_err", 64'(out_err), 64'h0);

    // Back-to-back stream sels 0,1,2
    in_valid = 1'b1;
    in_sel   = 2'd0;
    @(negedge clk);
    check("stream0", 64'(out_data), 64'hA);
    in_sel = 2'd1;
    @(negedge clk);
    check("stream1", 64'(out_data), 64'hB);
    in_sel = 2'd2;
    @(negedge clk);
    check("stream2", 64'(out_data), 64'hC);
    check("stream2_valid", 64'(out_valid), 64'h1);
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_drained", 64'(out_valid), 64'h0);

    // Out-of-range select
    in_sel   = 2'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("oor_data", 64'(out_data), 64'h0);
    check("oor_err", 64'(out_err), 64'h1);
    check("oor_valid", 64'(out_valid), 64'h1);
`ifdef MUX_N_REG_STATS_EN
    check("oor_count", 64'(err_count), 64'h1);
`endif
    @(negedge clk);

    // Backpressure: A then B fill main and skid
    out_ready = 1'b0;
    in_sel    = 2'd0;
    in_valid  = 1'b1;
    @(negedge clk);
    check("bp_a_data", 64'(out_data), 64'hA);
    check("bp_a_ready", 64'(in_ready), 64'h1);
    in_sel = 2'd1;
    @(negedge clk);
    check("bp_two_ready", 64'(in_ready), 64'h0);
    check("bp_two_data", 64'(out_data), 64'hA);
    in_sel = 2'd2;  // offered while full; must be ignored
    @(negedge clk);
    check("bp_hold_data", 64'(out_data), 64'hA);
    check("bp_hold_err", 64'(out_err), 64'h0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_b_data", 64'(out_data), 64'hB);
    check("bp_b_ready", 64'(in_ready), 64'h1);
    @(negedge clk);
    check("bp_empty", 64'(out_valid), 64'h0);

    // Reset while holding two beats
    out_ready = 1'b0;
    in_sel    = 2'd0;
    in_valid  = 1'b1;
    @(negedge clk);
    in_sel = 2'd1;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_full", 64'(in_ready), 64'h0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'h0);
    check("async_rst_ready", 64'(in_ready), 64'h1);
    check("async_rst_data", 64'(out_data), 64'h0);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_beat", 64'(out_valid), 64'h0);
    end

    // Mixed traffic with irregular backpressure
    for (int i = 0; i < 48; i++) begin
      in_data   = {32'(i * 7 + 3), 32'(i * 5 + 2), 32'(i * 11 + 1)};
      in_valid  = (i % 3) != 0;
      in_sel    = SW'(i % 4);
      out_ready = (i % 5) != 1 && (i % 7) != 2;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("mixed_drained", 64'(out_valid), 64'h0);

`ifdef MUX_N_REG_STATS_EN
    // Drive the counter to saturation, then one more error beat
    in_sel   = 2'd3;
    in_valid = 1'b1;
    repeat (65535) @(negedge clk);
    check("sat_reach", 64'(err_count), 64'hFFFF);
    @(negedge clk);
    check("sat_hold", 64'(err_count), 64'hFFFF);
    // Clear coincident with an error beat
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    in_valid  = 1'b0;
    check("clr_priority", 64'(err_count), 64'h0);
    repeat (3) @(negedge clk);
`endif

    run_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
